// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: command handshake, register-file bus and status signals of the sequencer.
interface regfile_sequencer_if #(parameter int DATA_W = 8, parameter int ADDR_W = 3);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs;
    logic [ADDR_W-1:0] cmd_rt;
    logic [DATA_W-1:0] cmd_imm;
    logic [ADDR_W-1:0] rf_read1;
    logic [ADDR_W-1:0] rf_read2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_reg_write;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              done;
    modport master (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm, rf_data1, rf_data2,
        output cmd_ready, rf_read1, rf_read2, rf_write_reg, rf_write_data, rf_reg_write,
               result, carry, zero, done
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm, rf_data1, rf_data2,
        input  cmd_ready, rf_read1, rf_read2, rf_write_reg, rf_write_data, rf_reg_write,
               result, carry, zero, done
    );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: four-cycle read/execute/write-back engine driving an 8x8 register file.
module regfile_sequencer #(parameter int DATA_W = 8, parameter int ADDR_W = 3) (
    input  logic                clock,
    input  logic                reset_n,
    regfile_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_LDI = 3'd4;
    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d, read1_q, read1_d, read2_q, read2_d, wreg_q, wreg_d;
    logic [DATA_W-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, wdata_q, wdata_d, result_q, result_d, alu_res;
    logic              we_q, we_d, carry_q, carry_d, zero_q, zero_d, done_q, done_d, alu_c, nop;
    logic [DATA_W:0]   sum, diff;

    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign diff    = {1'b0, a_q} - {1'b0, b_q};
    assign nop     = op_q[2] & op_q[1];
    // MOV falls through to A; NOP never reaches the result registers
    assign alu_res = (op_q == OP_ADD) ? sum[DATA_W-1:0] :
                     (op_q == OP_SUB) ? diff[DATA_W-1:0] :
                     (op_q == OP_AND) ? (a_q & b_q) :
                     (op_q == OP_OR)  ? (a_q | b_q) :
                     (op_q == OP_LDI) ? imm_q : a_q;
    assign alu_c   = (op_q == OP_ADD) ? sum[DATA_W] : (op_q == OP_SUB) ? diff[DATA_W] : 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            read1_q  <= '0;
            read2_q  <= '0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            read1_q  <= read1_d;
            read2_q  <= read2_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        a_d      = a_q;
        b_d      = b_q;
        read1_d  = read1_q;
        read2_d  = read2_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: if (bus.cmd_valid) begin
                op_d    = bus.cmd_op;
                rd_d    = bus.cmd_rd;
                imm_d   = bus.cmd_imm;
                read1_d = bus.cmd_rs;
                read2_d = bus.cmd_rt;
                state_d = READ;
            end
            READ: begin
                a_d     = bus.rf_data1;
                b_d     = bus.rf_data2;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = nop ? result_q : alu_res;
                carry_d  = nop ? carry_q : alu_c;
                zero_d   = nop ? zero_q : (alu_res == '0);
                wreg_d   = rd_q;
                wdata_d  = result_d;
                we_d     = !nop && (rd_q != '0);
                state_d  = WRITE;
            end
            WRITE: begin
                we_d    = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready     = (state_q == IDLE);
    assign bus.rf_read1      = read1_q;
    assign bus.rf_read2      = read2_q;
    assign bus.rf_write_reg  = wreg_q;
    assign bus.rf_write_data = wdata_q;
    assign bus.rf_reg_write  = we_q;
    assign bus.result        = result_q;
    assign bus.carry         = carry_q;
    assign bus.zero          = zero_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: attaches an 8x8 register file and checks commands against an arithmetic model.
module tb_regfile_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] rf [8];
    int ref_rf [8];
    int m_res, m_c, m_z;
    int total = 0, bad = 0;
    bit rst_win = 0, rst_we = 0;

    regfile_sequencer_if bus ();
    regfile_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    always @(posedge clock) if (bus.rf_reg_write && bus.rf_write_reg != 3'd0) rf[bus.rf_write_reg] <= bus.rf_write_data;
    always @(negedge clock) begin
        bus.rf_data1 <= rf[bus.rf_read1];
        bus.rf_data2 <= rf[bus.rf_read2];
    end
    always @(posedge clock) if (rst_win && bus.rf_reg_write) rst_we = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, rd, rs, rt, input logic [7:0] imm);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_rd = rd;
        bus.cmd_rs = rs;
        bus.cmd_rt = rt;
        bus.cmd_imm = imm;
    endtask

    task automatic scramble();
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'($urandom);
        bus.cmd_rd = 3'($urandom);
        bus.cmd_rs = 3'($urandom);
        bus.cmd_rt = 3'($urandom);
        bus.cmd_imm = 8'($urandom);
    endtask

    task automatic run_cmd(input logic [2:0] op, rd, rs, rt, input logic [7:0] imm);
        int a, b, r, c;
        bit nop, we;
        a = ref_rf[rs];
        b = ref_rf[rt];
        r = m_res;
        c = m_c;
        nop = (op >= 3'd6);
        case (op)
            3'd0: begin r = (a + b) % 256; c = int'((a + b) > 255); end
            3'd1: begin r = (a - b + 256) % 256; c = int'(a < b); end
            3'd2: begin r = a & b; c = 0; end
            3'd3: begin r = a | b; c = 0; end
            3'd4: begin r = int'(imm); c = 0; end
            3'd5: begin r = a; c = 0; end
            default: ;
        endcase
        if (!nop) begin
            m_res = r;
            m_c = c;
            m_z = int'(r == 0);
        end
        we = !nop && rd != 3'd0;
        check("ready_idle", bus.cmd_ready, 1);
        drive(op, rd, rs, rt, imm);
        tick();
        scramble();
        check("read1", bus.rf_read1, rs);
        check("read2", bus.rf_read2, rt);
        check("ready_busy", bus.cmd_ready, 0);
        check("done_read", bus.done, 0);
        tick();
        check("we_exec", bus.rf_reg_write, 0);
        tick();
        check("we_write", bus.rf_reg_write, we);
        if (we) begin
            check("wreg", bus.rf_write_reg, rd);
            check("wdata", bus.rf_write_data, m_res);
            ref_rf[rd] = m_res;
        end
        check("result", bus.result, m_res);
        check("carry", bus.carry, m_c);
        check("zero", bus.zero, m_z);
        check("done_write", bus.done, 0);
        tick();
        check("done", bus.done, 1);
        check("we_done", bus.rf_reg_write, 0);
        check("ready_done", bus.cmd_ready, 1);
        check("rf_rd", rf[rd], ref_rf[rd]);
        check("rf_r0", rf[0], 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf[i] = 8'h00;
            ref_rf[i] = 0;
        end
        m_res = 0; m_c = 0; m_z = 0;
        scramble();
        repeat (3) tick();
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_outs", {bus.rf_read1, bus.rf_read2, bus.rf_write_reg, bus.rf_write_data,
                           bus.rf_reg_write, bus.result, bus.carry, bus.zero, bus.done}, 0);
        reset_n = 1'b1;
        tick();
        run_cmd(3'd4, 3'd1, 3'd0, 3'd0, 8'h2A);
        run_cmd(3'd4, 3'd1, 3'd0, 3'd0, 8'hF0);
        run_cmd(3'd4, 3'd2, 3'd0, 3'd0, 8'h20);
        run_cmd(3'd0, 3'd3, 3'd1, 3'd2, 8'h00);
        run_cmd(3'd1, 3'd4, 3'd2, 3'd1, 8'h00);
        run_cmd(3'd1, 3'd5, 3'd1, 3'd1, 8'h00);
        run_cmd(3'd4, 3'd0, 3'd0, 3'd0, 8'hFF);
        run_cmd(3'd4, 3'd1, 3'd0, 3'd0, 8'h05);
        run_cmd(3'd0, 3'd2, 3'd1, 3'd1, 8'h00);
        // reset lands in EXEC of ADD r6; its write must never be issued
        rst_win = 1;
        drive(3'd0, 3'd6, 3'd1, 3'd2, 8'h00);
        tick();
        scramble();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_ready", bus.cmd_ready, 1);
        check("midrst_outs", {bus.rf_read1, bus.rf_read2, bus.rf_write_reg, bus.rf_write_data,
                              bus.rf_reg_write, bus.result, bus.carry, bus.zero, bus.done}, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        rst_win = 0;
        check("midrst_no_write", rst_we, 0);
        check("midrst_r6", rf[6], ref_rf[6]);
        m_res = 0; m_c = 0; m_z = 0;
        run_cmd(3'd4, 3'd6, 3'd0, 3'd0, 8'h77);
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle initiator that drives the CPU's 8 x 8-bit register file.
- The register file writes on the rising clock edge when its write enable is high, ignores writes to register 0, and latches both read ports on the falling clock edge.
- This block accepts one register-to-register command at a time over a valid/ready handshake and issues both read addresses.
- It captures the operands, runs an 8-bit ALU op, and issues the write-back. It also reports the result and flags to the control path.

Parameters:
- DATA_W, 8, register data width; the register file and all datapath widths are fixed at 8.
- ADDR_W, 3, register address width (8 registers).

Ports:
- clock  in  1  system clock, rising-edge logic.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LDI, 101 MOV, 110 and 111 NOP.
- cmd_rd  in  3  destination register.
- cmd_rs  in  3  source A register.
- cmd_rt  in  3  source B register.
- cmd_imm  in  8  immediate, used by LDI only.
- rf_read1  out  3  register-file read address 1, driven from cmd_rs.
- rf_read2  out  3  register-file read address 2, driven from cmd_rt.
- rf_data1  in  8  register-file read data 1.
- rf_data2  in  8  register-file read data 2.
- rf_write_reg  out  3  register-file write address.
- rf_write_data  out  8  register-file write data.
- rf_reg_write  out  1  register-file write enable.
- result  out  8  last ALU result.
- carry  out  1  last carry/borrow.
- zero  out  1  high when the last result is 0x00.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset: clock is the single clock; reset_n is asynchronous and active-low.
  - While reset_n=0, state is IDLE and every registered output is 0: rf_read1, rf_read2, rf_write_reg, rf_write_data, rf_reg_write, result, carry, zero, done.
  - cmd_ready=1 (IDLE). Any in-flight command is discarded and no write is issued.
- FSM states IDLE, READ, EXEC, WRITE. cmd_ready = (state==IDLE), combinational.
- IDLE: on a rising edge with cmd_valid & cmd_ready:
  - latch op, rd and imm;
  - rf_read1<=rs, rf_read2<=rt;
  - go to READ.
  - cmd_* is sampled only at this edge.
- READ: the register file latches its read data at this cycle's falling edge. At the next rising edge, capture rf_data1 as A and rf_data2 as B, then go to EXEC.
- EXEC: compute combinationally; at the rising edge register the results and go to WRITE.
  - ADD: 9-bit A+B; result = low 8 bits, carry = bit 8.
  - SUB: result = A-B mod 256; carry = 1 iff A<B (borrow).
  - AND / OR: bitwise; carry=0.
  - LDI: result=imm; carry=0.
  - MOV: result=A; carry=0.
  - NOP: result, carry and zero keep their previous values.
  - For all ops except NOP: zero = (result==0).
  - rf_write_reg<=rd, rf_write_data<=result.
  - rf_reg_write<=1 iff op is not NOP and rd!=0. Writes to r0 are suppressed here as well as in the register file.
- WRITE: rf_reg_write is held for exactly this cycle; the register file commits at the rising edge ending WRITE. At that edge: rf_reg_write<=0, done<=1, go to IDLE.
- done is high for exactly one cycle: the first IDLE cycle after WRITE.
- Latency: done rises 3 rising edges after the accept edge, so the initiation interval is 4 cycles. A command may be accepted in the done cycle.
- No read-after-write hazard: the previous write commits at the edge entering IDLE, before the next READ-cycle falling edge.
- rf_read1/rf_read2 hold their last value between commands. rf_write_reg/rf_write_data hold their values after WRITE.
- Reset asserted in any state returns the block to IDLE immediately. A write whose WRITE cycle is cut short by reset is not guaranteed to commit; no further write is issued.

Test Plan:
- Bench: the team's 8x8 register file attached to the rf_* ports.
- Reset, then LDI r1,0x2A -> rf_reg_write=1 with rf_write_reg=1 and rf_write_data=0x2A in the WRITE cycle; done at accept+3; result=0x2A, zero=0, carry=0; register file r1=0x2A.
- Preload r1=0xF0, r2=0x20, then ADD r3=r1+r2 -> result 0x10, carry=1, zero=0; r3=0x10.
- SUB r4=r2-r1 -> 0x30, carry=1. Then SUB r5=r1-r1 -> 0x00, zero=1, carry=0.
- LDI r0,0xFF -> rf_reg_write stays 0 for the whole command; result=0xFF; done pulses; r0 reads 0x00.
- LDI r1,0x05 followed by ADD r2=r1+r1, presented on the done cycle -> accepted in that cycle; result 0x0A; r2=0x0A.
- reset_n low during EXEC of ADD r6 -> all outputs 0 and cmd_ready=1 immediately; rf_reg_write never asserts; r6 unchanged; the next LDI completes normally.
